// File: rtl/mmio_uart_tx_fifo_pkg.sv
// uart_pkg: shared constants for the MMIO UART transmitter.
//   - transmit FSM state encoding
//   - status word bit positions
//   - default bus addresses for the data and status registers
package uart_pkg;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_MSB = 15;

    localparam logic [31:0] DEF_DATA_ADDR   = 32'h0000_2001;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_2002;

endpackage

// File: rtl/mmio_uart_tx_fifo_if.sv
// CPU data-memory bus as seen by the UART transmitter.
//   bus_addr/bus_wdata/bus_write/bus_read : driven by the CPU (master)
//   bus_rdata                             : status word back to the CPU
//   stall                                 : request to freeze the CPU
interface mmio_uart_tx_fifo_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_write;
    logic        bus_read;
    logic [31:0] bus_rdata;
    logic        stall;

    modport master (
        output bus_addr, bus_wdata, bus_write, bus_read,
        input  bus_rdata, stall
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_write, bus_read,
        output bus_rdata, stall
    );
endinterface

// File: rtl/mmio_uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage.
//   clk, rstn          : clock, async active-low reset
//   i_push, i_wdata    : write request/data (ignored while full)
//   i_pop              : read request (ignored while empty)
//   o_rdata            : head entry (valid while not empty)
//   o_full, o_empty    : occupancy flags
//   o_count            : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Full is the pre-edge flag, so a push into a full FIFO is refused
    // even when a pop frees a slot on the same edge.
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx_fifo.sv
// mmio_uart_tx_fifo: memory-mapped 8N1 UART transmitter with a TX FIFO.
//   clk, rstn  : clock, async active-low reset
//   bus        : CPU bus (slave side) - byte writes to DATA_ADDR push,
//                STATUS_ADDR reads return status, writes with bit3 clear
//                the sticky overflow flag; stall requested on full FIFO
//   tx         : registered serial output, idle high
//   irq_empty  : FIFO empty and transmitter idle
//
//   state    | meaning
//   ST_IDLE  | line high, waiting for a byte in the FIFO
//   ST_START | start bit (low) for BAUD_DIV clocks
//   ST_DATA  | 8 data bits LSB first, BAUD_DIV clocks each
//   ST_STOP  | stop bit (high); last clock may chain into the next frame
module mmio_uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int          BAUD_DIV      = 104,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [31:0] DATA_ADDR     = DEF_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR   = DEF_STATUS_ADDR,
    parameter bit          STALL_ON_FULL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    mmio_uart_tx_fifo_if.slave   bus,
    output logic                 tx,
    output logic                 irq_empty
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    tx_state_t   r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_ovf;

    logic          w_data_wr;
    logic          w_stat_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic [7:0]    w_cnt_field;
    logic          w_busy;
    logic          w_bit_end;

    assign w_data_wr = bus.bus_write && (bus.bus_addr == DATA_ADDR);
    assign w_stat_wr = bus.bus_write && (bus.bus_addr == STATUS_ADDR);
    assign w_push    = w_data_wr && !w_full;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_bit_end = (r_baud_cnt == 16'd0);

    // Pop when idle, or on the final stop clock so frames chain without a gap.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_wdata (bus.bus_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // The status count field is 8 bits; a completely full 256-deep FIFO
    // reports 255 rather than wrapping to 0.
    assign w_cnt_field = (32'(w_count) > 32'd255) ? 8'hFF : 8'(w_count);

    assign bus.stall = STALL_ON_FULL && w_data_wr && w_full;
    assign tx        = r_tx;
    assign irq_empty = w_empty && !w_busy;

    always_comb begin
        bus.bus_rdata = '0;
        if (bus.bus_read && (bus.bus_addr == STATUS_ADDR)) begin
            bus.bus_rdata[STAT_BUSY]                 = w_busy;
            bus.bus_rdata[STAT_FULL]                 = w_full;
            bus.bus_rdata[STAT_EMPTY]                = w_empty;
            bus.bus_rdata[STAT_OVF]                  = r_ovf;
            bus.bus_rdata[STAT_CNT_MSB:STAT_CNT_LSB] = w_cnt_field;
        end
    end

    // A new drop wins over a coincident clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (!STALL_ON_FULL && w_data_wr && w_full) begin
            r_ovf <= 1'b1;
        end else if (w_stat_wr && bus.bus_wdata[STAT_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_START;
                        r_shift    <= w_head;
                        r_baud_cnt <= BAUD_LAST;
                        r_tx       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state    <= ST_DATA;
                        r_baud_cnt <= BAUD_LAST;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= BAUD_LAST;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_state    <= ST_START;
                            r_shift    <= w_head;
                            r_baud_cnt <= BAUD_LAST;
                            r_tx       <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx_fifo.sv
// Bench for mmio_uart_tx_fifo. Two instances share clock and reset:
// channel 0 stalls on a full FIFO, channel 1 drops and flags overflow.
// A queue/timeline model predicts tx, irq_empty, stall and bus_rdata,
// and a negedge process compares both channels every cycle.
module tb_mmio_uart_tx_fifo;
    import uart_pkg::*;

    localparam int B     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * B;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr_d  [2];
    logic [31:0] wdata_d [2];
    logic        wr_d    [2];
    logic        rd_d    [2];
    logic [31:0] rdata_o [2];
    logic        stall_o [2];
    logic        tx_o    [2];
    logic        irq_o   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    mmio_uart_tx_fifo_if bif0 ();
    mmio_uart_tx_fifo_if bif1 ();

    assign bif0.bus_addr  = addr_d[0];
    assign bif0.bus_wdata = wdata_d[0];
    assign bif0.bus_write = wr_d[0];
    assign bif0.bus_read  = rd_d[0];
    assign rdata_o[0]     = bif0.bus_rdata;
    assign stall_o[0]     = bif0.stall;
    assign bif1.bus_addr  = addr_d[1];
    assign bif1.bus_wdata = wdata_d[1];
    assign bif1.bus_write = wr_d[1];
    assign bif1.bus_read  = rd_d[1];
    assign rdata_o[1]     = bif1.bus_rdata;
    assign stall_o[1]     = bif1.stall;

    mmio_uart_tx_fifo #(
        .BAUD_DIV (B), .FIFO_DEPTH (D), .STALL_ON_FULL (1'b1)
    ) u_dut_stall (
        .clk (clk), .rstn (rstn), .bus (bif0.slave),
        .tx (tx_o[0]), .irq_empty (irq_o[0])
    );

    mmio_uart_tx_fifo #(
        .BAUD_DIV (B), .FIFO_DEPTH (D), .STALL_ON_FULL (1'b0)
    ) u_dut_drop (
        .clk (clk), .rstn (rstn), .bus (bif1.slave),
        .tx (tx_o[1]), .irq_empty (irq_o[1])
    );

    // ---------------- model ----------------
    typedef logic [7:0] bq_t[$];
    bq_t        mq  [2];
    bit         act [2];
    int         t   [2];
    logic [7:0] cur [2];
    bit         ovf [2];

    function automatic void model_step(int c);
        bit wdat      = wr_d[c] && (addr_d[c] == DEF_DATA_ADDR);
        bit was_full  = (mq[c].size() == D);
        bit was_empty = (mq[c].size() == 0);
        if (!act[c] || t[c] == FRAME - 1) begin
            if (!was_empty) begin
                cur[c] = mq[c].pop_front();
                act[c] = 1'b1;
                t[c]   = 0;
            end else begin
                act[c] = 1'b0;
            end
        end else begin
            t[c] = t[c] + 1;
        end
        if (wdat && !was_full) mq[c].push_back(wdata_d[c][7:0]);
        if (wdat && was_full && c == 1) ovf[c] = 1'b1;
        else if (wr_d[c] && addr_d[c] == DEF_STATUS_ADDR && wdata_d[c][3]) ovf[c] = 1'b0;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < 2; c++) begin
                mq[c].delete();
                act[c] = 1'b0;
                t[c]   = 0;
                ovf[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) model_step(c);
        end
    end

    function automatic logic exp_tx(int c);
        if (!act[c]) return 1'b1;
        if (t[c] < B) return 1'b0;
        if (t[c] < 9 * B) return cur[c][(t[c] - B) / B];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rdata(int c);
        int n = mq[c].size();
        if (!(rd_d[c] && addr_d[c] == DEF_STATUS_ADDR)) return 32'h0;
        return (32'(n) << 8) | (ovf[c] ? 32'h8 : 32'h0) | (n == 0 ? 32'h4 : 32'h0)
             | (n == D ? 32'h2 : 32'h0) | (act[c] ? 32'h1 : 32'h0);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            check($sformatf("ch%0d_tx", c), 32'(tx_o[c]), 32'(exp_tx(c)));
            check($sformatf("ch%0d_irq", c), 32'(irq_o[c]),
                  32'(!act[c] && mq[c].size() == 0));
            check($sformatf("ch%0d_stall", c), 32'(stall_o[c]),
                  32'(c == 0 && wr_d[c] && addr_d[c] == DEF_DATA_ADDR && mq[c].size() == D));
            check($sformatf("ch%0d_rdata", c), rdata_o[c], exp_rdata(c));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_bus(int c);
        addr_d[c]  = DEF_STATUS_ADDR;
        wdata_d[c] = 32'h0;
        wr_d[c]    = 1'b0;
        rd_d[c]    = 1'b1;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds a write until it is accepted; returns the number of stalled cycles.
    task automatic bus_wr(input int c, input logic [31:0] a, input logic [31:0] d, output int nstall);
        addr_d[c]  = a;
        wdata_d[c] = d;
        wr_d[c]    = 1'b1;
        rd_d[c]    = 1'b0;
        nstall     = 0;
        forever begin
            @(negedge clk);
            if (stall_o[c] !== 1'b1) break;
            nstall++;
            if (nstall > 300) begin
                check($sformatf("ch%0d_stall_timeout", c), 32'(stall_o[c]), 32'h0);
                break;
            end
        end
        @(posedge clk);
        #1;
        idle_bus(c);
    endtask

    task automatic wait_idle(input int c, input int budget, input string nm, output int at);
        int n = 0;
        forever begin
            @(negedge clk);
            if (irq_o[c] === 1'b1) break;
            n++;
            if (n > budget) begin
                check({nm, "_timeout"}, 32'(irq_o[c]), 32'h1);
                break;
            end
        end
        at = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int         ns;
        int         at;
        int         c0;
        logic       smp [41];
        logic [9:0] frame_a5;
        int         exp_stalls [6];

        idle_bus(0);
        idle_bus(1);
        #12;
        check("reset_tx", 32'(tx_o[0]), 32'h1);
        check("reset_irq", 32'(irq_o[1]), 32'h1);
        check("reset_status", rdata_o[0], 32'h4);
        #10 rstn = 1'b1;
        tick(1);

        // Single byte 8'hA5: start, LSB-first data, stop.
        frame_a5 = {1'b1, 8'hA5, 1'b0};
        bus_wr(0, DEF_DATA_ADDR, 32'hA5, ns);
        c0 = cyc;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            smp[i] = tx_o[0];
        end
        check("a5_pre_start", 32'(smp[0]), 32'h1);
        for (int j = 0; j < 10; j++)
            for (int k = 0; k < B; k++)
                check($sformatf("a5_bit%0d_clk%0d", j, k), 32'(smp[1 + B * j + k]), 32'(frame_a5[j]));
        wait_idle(0, 20, "a5_idle", at);
        check("a5_irq_cycle", 32'(at - c0), 32'd41);

        // Three back-to-back bytes, no idle gap.
        bus_wr(0, DEF_DATA_ADDR, 32'h01, ns);
        c0 = cyc;
        bus_wr(0, DEF_DATA_ADDR, 32'h02, ns);
        bus_wr(0, DEF_DATA_ADDR, 32'h03, ns);
        tick(60);
        @(negedge clk);
        check("b2b_mid_status", rdata_o[0], 32'h101);
        wait_idle(0, 200, "b2b_idle", at);
        check("b2b_total_clocks", 32'(at - c0 - 1), 32'd120);

        // Stall: sixth write waits for the first pop.
        exp_stalls = '{0, 0, 0, 0, 0, 37};
        for (int i = 0; i < 6; i++) begin
            bus_wr(0, DEF_DATA_ADDR, 32'(8'h10 + i), ns);
            check($sformatf("stall_cycles_w%0d", i + 1), 32'(ns), 32'(exp_stalls[i]));
        end
        wait_idle(0, 6 * FRAME + 50, "stall_idle", at);

        // Overflow: seventh and sixth writes dropped, sticky flag, clear.
        for (int i = 0; i < 7; i++) bus_wr(1, DEF_DATA_ADDR, 32'(8'h20 + i), ns);
        @(negedge clk);
        check("ovf_status", rdata_o[1], 32'h40B);
        bus_wr(1, DEF_STATUS_ADDR, 32'h8, ns);
        @(negedge clk);
        check("ovf_cleared", rdata_o[1], 32'h403);
        wait_idle(1, 5 * FRAME + 50, "ovf_idle", at);

        // Other addresses: no side effects, reads return 0.
        bus_wr(0, 32'h2003, 32'h55, ns);
        bus_wr(0, 32'h0000, 32'hFF, ns);
        addr_d[0] = 32'h2000;
        @(negedge clk);
        check("other_addr_read", rdata_o[0], 32'h0);
        idle_bus(0);
        @(negedge clk);
        check("other_addr_status", rdata_o[0], 32'h4);
        tick(1);

        // Reset during data bit 3 of 8'hC3.
        bus_wr(0, DEF_DATA_ADDR, 32'hC3, ns);
        tick(18);
        check("rst_pre_bit3", 32'(tx_o[0]), 32'h0);
        rstn = 1'b0;
        #1;
        check("rst_tx_now", 32'(tx_o[0]), 32'h1);
        check("rst_status_now", rdata_o[0], 32'h4);
        @(negedge clk);
        #2 rstn = 1'b1;
        tick(1);
        bus_wr(0, DEF_DATA_ADDR, 32'h3C, ns);
        wait_idle(0, FRAME + 20, "rst_resend_idle", at);

        // Wrap-around: 20 bytes through the 4-deep FIFO.
        for (int i = 0; i < 20; i++) bus_wr(0, DEF_DATA_ADDR, 32'(8'((i * 37 + 5) & 8'hFF)), ns);
        wait_idle(0, 20 * FRAME + 100, "wrap_idle", at);
        @(negedge clk);
        check("wrap_final_status", rdata_o[0], 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
